clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
Checker/receiver for a divided clock produced by the team's divide-by-N dividers (e.g. the divide-by-9, 50%-duty divider). Samples the divided clock in the source clock domain and measures its period and high time in source-clock cycles. Declares lock after consecutive correct periods and flags a sticky error on any period/duty violation or stalled divider output. Sits beside each divider instance as a built-in self-check, and its status is routed to the test/status register block.

Parameters:
DIV, 9, expected divide ratio in clk cycles (>=2).
CNT_W, 8, width of period/high counters; must hold 2*DIV.
LOCK_CNT, 4, consecutive good periods required to assert locked (>=1).

Ports:
clk  input  1  source clock; the clock the monitored divider divides.
reset  input  1  synchronous, active-high reset.
div_in  input  1  divided clock under test (may change on either clk edge).
clear_err  input  1  one-cycle pulse that clears the sticky err.
locked  output  1  divider output verified correct.
err  output  1  sticky error flag.
meas_valid  output  1  one-cycle pulse when new measurements are published.
period_meas  output  CNT_W  last measured period in clk cycles.
high_meas  output  CNT_W  last measured high time in clk cycles.
VDD  inout  1  power pin; no logic.
VSS  inout  1  ground pin; no logic.

Behaviour:
- Reset: synchronous on posedge clk when reset=1. All flops clear: locked=0, err=0, meas_valid=0, period_meas=0, high_meas=0, state=SEARCH. Reset mid-operation aborts any measurement.
- Input path: div_in -> s1 -> s2 (2-flop synchronizer); s3 <= s2. rise = s2 & ~s3; fall = ~s2 & s3. Latency from div_in to edge detect is 2 clk cycles.
- Counters, posedge only:
  - per_cnt loads 1 on rise; otherwise it increments, saturating at 2*DIV.
  - hi_cnt loads 1 on rise; it increments while s2=1 and holds otherwise.
- Measurement: on rise in ACQUIRE or LOCKED:
  - period_meas <= per_cnt (value before the reload).
  - high_meas <= hi_cnt.
  - meas_valid=1 for that one cycle.
- A period is good iff period_meas==DIV and high_meas is in {DIV/2, (DIV+1)/2} (integer division). DIV=9 accepts high 4 or 5; DIV=8 accepts only 4.
- FSM states: SEARCH, ACQUIRE, LOCKED. good_cnt counts good periods.
  - SEARCH: the first rise is discarded (no prior edge). Go to ACQUIRE with good_cnt=0; no meas_valid.
  - ACQUIRE, rise with good period: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED; locked=1 from the next cycle.
  - ACQUIRE, rise with bad period: good_cnt=0, stay in ACQUIRE, err unchanged.
  - LOCKED, rise with bad period: err<=1, locked<=0, go to ACQUIRE with good_cnt=0.
  - Timeout: per_cnt reaches 2*DIV with no rise, in ACQUIRE or LOCKED. Go to SEARCH and set locked<=0. Set err<=1 only if the state was LOCKED. No meas_valid is produced.
- err is sticky. clear_err clears it on the next edge. If a new error occurs in the same cycle as clear_err, the error wins and err=1.
- The locked and err outputs are registered, so they update one cycle after the rise that decides them.

Decomposition:
- Shared package clkdiv_pkg holds:
  - the state enum (SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2);
  - the default DIV/CNT_W/LOCK_CNT constants shared with the divider blocks;
  - a helper function for the good-period check.
- One sub-module, sync_edge_det: the 2-flop synchronizer plus the s3 delay, with outputs level, rise and fall. It is reusable by other divider checkers.

Test Plan:
1. DIV=9. Drive an ideal divide-by-9 waveform (high 5/low 4 and high 4/low 5 alternating; half-cycle edges allowed). Required: the first rise is discarded; rises 2-5 give meas_valid with period_meas=9 and high_meas of 4 or 5; locked=1 the cycle after rise 5; err=0.
2. After lock, insert one period of 10 cycles. Required: period_meas=10, err=1 and locked=0 one cycle after that rise. Four subsequent good periods relock (locked=1); err stays 1 until a clear_err pulse, then err=0.
3. After lock, send a period of 9 with high time 7. Required: high_meas=7, err=1, locked=0, state ACQUIRE.
4. After lock, hold div_in low. Required: after 18 cycles with no rise, locked=0 and err=1 with no meas_valid, state SEARCH. Restarting the waveform relocks after 1 discarded rise plus 4 good periods.
5. clear_err asserted in the same cycle as a detected bad period while LOCKED. Required: err remains 1.
6. Assert reset for one cycle mid-ACQUIRE with div_in high. Required: all outputs 0 after that edge. The first rise after reset release is discarded and no spurious err occurs.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the divide-by-N clock dividers and their monitors.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  localparam int DEF_DIV      = 9;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LOCK_CNT = 4;

  // Odd ratios accept either rounding of the half period; even ratios need an exact half.
  function automatic logic period_good(input int period, input int high, input int div);
    return (period == div) && ((high == div / 2) || (high == (div + 1) / 2));
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus one delay stage, giving the synchronized level and its edges.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign level = s2_reg;
  assign rise  = s2_reg & ~s3_reg;
  assign fall  = ~s2_reg & s3_reg;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock, declares lock after a run of good
// periods and raises a sticky error on violations or a stalled divider output.
module clk_div_monitor
  import clkdiv_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] high_meas,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(2 * DIV);
  localparam int               LC_W = $clog2(LOCK_CNT + 1);
  localparam logic [LC_W-1:0]  LOCK_C = LC_W'(LOCK_CNT);

  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] per_cnt_reg;
  logic [CNT_W-1:0] hi_cnt_reg;
  logic [LC_W-1:0]  good_cnt_reg;
  logic [LC_W-1:0]  good_inc;
  logic             period_ok;
  mon_state_t       state_reg;
  logic             locked_reg;
  logic             err_reg;
  logic             meas_valid_reg;
  logic [CNT_W-1:0] period_meas_reg;
  logic [CNT_W-1:0] high_meas_reg;

  // Power pins carry no logic; the falling edge is not needed by this checker.
  wire unused_ok = ^{VDD, VSS, fall};

  sync_edge_det u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (div_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
    end else if (rise) begin
      per_cnt_reg <= CNT_W'(1);
      hi_cnt_reg  <= CNT_W'(1);
    end else begin
      if (per_cnt_reg != SAT) per_cnt_reg <= per_cnt_reg + 1'b1;
      if (level) hi_cnt_reg <= hi_cnt_reg + 1'b1;
    end
  end

  // Counters still hold the just-finished period during the rise cycle.
  assign period_ok = period_good(int'(per_cnt_reg), int'(hi_cnt_reg), DIV);
  assign good_inc  = good_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= SEARCH;
      good_cnt_reg    <= '0;
      locked_reg      <= 1'b0;
      err_reg         <= 1'b0;
      meas_valid_reg  <= 1'b0;
      period_meas_reg <= '0;
      high_meas_reg   <= '0;
    end else begin
      meas_valid_reg <= 1'b0;
      if (clear_err) err_reg <= 1'b0;
      case (state_reg)
        SEARCH: begin
          if (rise) begin
            state_reg    <= ACQUIRE;
            good_cnt_reg <= '0;
          end
        end
        ACQUIRE, LOCKED: begin
          if (rise) begin
            meas_valid_reg  <= 1'b1;
            period_meas_reg <= per_cnt_reg;
            high_meas_reg   <= hi_cnt_reg;
            if (period_ok) begin
              if (state_reg == ACQUIRE) begin
                good_cnt_reg <= good_inc;
                if (good_inc == LOCK_C) begin
                  state_reg  <= LOCKED;
                  locked_reg <= 1'b1;
                end
              end
            end else begin
              good_cnt_reg <= '0;
              if (state_reg == LOCKED) begin
                err_reg    <= 1'b1;
                locked_reg <= 1'b0;
                state_reg  <= ACQUIRE;
              end
            end
          end else if (per_cnt_reg == SAT) begin
            // Stalled divider: a lost lock is an error, an unfinished acquisition is not.
            if (state_reg == LOCKED) err_reg <= 1'b1;
            locked_reg   <= 1'b0;
            state_reg    <= SEARCH;
            good_cnt_reg <= '0;
          end
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

  assign locked      = locked_reg;
  assign err         = err_reg;
  assign meas_valid  = meas_valid_reg;
  assign period_meas = period_meas_reg;
  assign high_meas   = high_meas_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus random periods against an event-level model.
module tb_clk_div_monitor;

  localparam int DIV      = 9;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             div_in;
  logic             clear_err;
  logic             locked;
  logic             err;
  logic             meas_valid;
  logic [CNT_W-1:0] period_meas;
  logic [CNT_W-1:0] high_meas;
  wire              vdd = 1'b1;
  wire              vss = 1'b0;

  clk_div_monitor #(.DIV(DIV), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk         (clk),
    .reset       (reset),
    .div_in      (div_in),
    .clear_err   (clear_err),
    .locked      (locked),
    .err         (err),
    .meas_valid  (meas_valid),
    .period_meas (period_meas),
    .high_meas   (high_meas),
    .VDD         (vdd),
    .VSS         (vss)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Model: works on whole periods (time between rises), not on clock-level state.
  typedef enum {M_SEARCH, M_ACQ, M_LOCK} mstate_t;
  mstate_t m_state   = M_SEARCH;
  int      streak    = 0;
  bit      m_locked  = 0;
  bit      m_err     = 0;
  int      last_rise = 0;
  int      last_high = 0;
  int      exp_p[$];
  int      exp_h[$];

  always @(negedge clk) begin
    if (meas_valid) begin
      if (exp_p.size() == 0) begin
        chk("spurious_meas_valid", 1, 0);
      end else begin
        chk("period_meas", period_meas, exp_p.pop_front());
        chk("high_meas", high_meas, exp_h.pop_front());
      end
    end
  end

  task automatic model_rise(input bit clr);
    int p;
    bit good;
    bit new_err;
    p = cyc - last_rise;
    new_err = 1'b0;
    if (m_state == M_SEARCH) begin
      m_state = M_ACQ;
      streak  = 0;
    end else begin
      exp_p.push_back(p);
      exp_h.push_back(last_high);
      good = (p == DIV) && (last_high == DIV / 2 || last_high == (DIV + 1) / 2);
      if (m_state == M_ACQ) begin
        if (good) begin
          streak++;
          if (streak >= LOCK_CNT) begin
            m_state  = M_LOCK;
            m_locked = 1'b1;
          end
        end else begin
          streak = 0;
        end
      end else if (!good) begin
        new_err  = 1'b1;
        m_locked = 1'b0;
        m_state  = M_ACQ;
        streak   = 0;
      end
    end
    if (new_err) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    last_rise = cyc;
  endtask

  task automatic end_checks(input string tag);
    if (m_state != M_SEARCH && (cyc - last_rise) > 2 * DIV) begin
      if (m_state == M_LOCK) m_err = 1'b1;
      m_locked = 1'b0;
      m_state  = M_SEARCH;
    end
    chk({tag, "_locked"}, locked, m_locked);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_meas_missing"}, exp_p.size(), 0);
  endtask

  // mode 0: no clear; 1: clear_err coincides with the rise decision; 2: clear during low phase.
  task automatic drive_period(input int h, input int l, input int mode, input string tag);
    model_rise(mode == 1);
    for (int i = 0; i < h + l; i++) begin
      div_in    = (i < h);
      clear_err = (mode == 1 && i == 2) || (mode == 2 && i == h);
      @(negedge clk);
    end
    clear_err = 1'b0;
    last_high = h;
    if (mode == 2) m_err = 1'b0;
    $display("period h=%0d l=%0d mode=%0d -> locked=%0b err=%0b (%s)", h, l, mode, locked, err, tag);
    end_checks(tag);
  endtask

  task automatic good_periods(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 0) drive_period(5, 4, 0, tag);
      else drive_period(4, 5, 0, tag);
    end
  endtask

  task automatic reset_mid_high();
    model_rise(1'b0);
    div_in    = 1'b1;
    clear_err = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_period_meas", period_meas, 0);
    chk("rst_high_meas", high_meas, 0);
    reset = 1'b0;
    m_state  = M_SEARCH;
    m_locked = 1'b0;
    m_err    = 1'b0;
    streak   = 0;
    exp_p.delete();
    exp_h.delete();
    // Releasing reset with div_in high looks like a fresh rise to the synchronizer.
    model_rise(1'b0);
    for (int i = 0; i < 9; i++) begin
      div_in = (i < 5);
      @(negedge clk);
    end
    last_high = 5;
    $display("reset mid-high -> locked=%0b err=%0b", locked, err);
    end_checks("after_reset");
  endtask

  initial begin
    int p;
    int h;
    int r;
    int mode;
    reset     = 1'b1;
    div_in    = 1'b0;
    clear_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_locked", locked, 0);
    chk("init_err", err, 0);
    chk("init_meas_valid", meas_valid, 0);
    chk("init_period_meas", period_meas, 0);
    chk("init_high_meas", high_meas, 0);
    reset = 1'b0;
    last_rise = cyc;
    @(negedge clk);

    good_periods(5, "t1_lock");
    drive_period(5, 5, 0, "t2_period10");
    good_periods(4, "t2_relock");
    drive_period(5, 4, 2, "t2_clear");
    drive_period(7, 2, 0, "t3_high7");
    drive_period(4, 5, 2, "t3_clear");
    good_periods(3, "t3_relock");
    drive_period(5, 30, 0, "t4_stall");
    good_periods(5, "t4_restart");
    drive_period(5, 4, 2, "t5_clear");
    drive_period(6, 4, 1, "t5_err_vs_clear");
    drive_period(9, 9, 0, "bnd_p18");
    drive_period(5, 4, 0, "bnd_meas18");
    drive_period(4, 5, 1, "bnd_clear_good");
    drive_period(3, 6, 0, "bnd_high3");
    good_periods(4, "pre_reset");
    drive_period(3, 6, 0, "t6_bad");
    reset_mid_high();
    good_periods(4, "t6_relock");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: p = 8;
        1: p = 10;
        2: p = 18;
        3: p = 25;
        4: p = 7;
        default: p = 9;
      endcase
      if (p == 9) h = $urandom_range(3, 6);
      else if (p == 25) h = $urandom_range(3, 10);
      else h = $urandom_range(3, p - 2);
      r = $urandom_range(0, 5);
      mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      drive_period(h, p - h, mode, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
